// File: rtl/pong_engine_if.sv
// pong_engine_if: player controls in, game state out, shared by engine, key logic and renderer.
interface pong_engine_if;
  logic       pause;
  logic [1:0] keys_left;
  logic [1:0] keys_right;
  logic [9:0] pad_left;
  logic [9:0] pad_right;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic [1:0] state;
  logic       tick;
  modport master (
    output pause, keys_left, keys_right,
    input  pad_left, pad_right, ball_x, ball_y, score_left, score_right, state, tick
  );
  modport slave (
    input  pause, keys_left, keys_right,
    output pad_left, pad_right, ball_x, ball_y, score_left, score_right, state, tick
  );
endinterface

// File: rtl/pong_engine.sv
// pong_engine: Pong game state (paddles, ball, scores, serve/play/over) advanced on a divided tick enable.
module pong_engine #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int PAD_W       = 8,
  parameter int PAD_H       = 64,
  parameter int PAD_DIST    = 16,
  parameter int BALL_SZ     = 8,
  parameter int PAD_SPEED   = 2,
  parameter int BALL_VX     = 2,
  parameter int TICK_DIV    = 200000,
  parameter int SERVE_TICKS = 60,
  parameter int MAX_SCORE   = 9
) (
  input logic clk,
  input logic rst,
  pong_engine_if.slave bus
);
  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int SC_W  = $clog2(SERVE_TICKS + 1);
  localparam logic [CNT_W-1:0] T_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [SC_W-1:0]  SC_LAST = SC_W'(SERVE_TICKS - 1);
  localparam logic [9:0] P_MAX  = 10'(SCREEN_H - PAD_H);
  localparam logic [9:0] P_SPD  = 10'(PAD_SPEED);
  localparam logic [9:0] P_HI   = P_MAX - P_SPD;
  localparam logic [9:0] P_INIT = 10'((SCREEN_H - PAD_H) / 2);
  localparam logic [9:0] CX     = 10'((SCREEN_W - BALL_SZ) / 2);
  localparam logic [8:0] CY     = 9'((SCREEN_H - BALL_SZ) / 2);
  localparam logic [3:0] MAX_S  = 4'(MAX_SCORE);
  localparam logic signed [11:0] V     = 12'(BALL_VX);
  localparam logic signed [11:0] V1    = 12'sd1;
  localparam logic signed [11:0] V2    = 12'sd2;
  localparam logic signed [11:0] LF    = 12'(PAD_DIST + PAD_W);
  localparam logic signed [11:0] RF    = 12'(SCREEN_W - PAD_DIST - PAD_W - BALL_SZ);
  localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - BALL_SZ);
  localparam logic signed [11:0] Y_MAX = 12'(SCREEN_H - BALL_SZ);
  localparam logic signed [11:0] BS    = 12'(BALL_SZ);
  localparam logic signed [11:0] HB    = 12'(BALL_SZ / 2);
  localparam logic signed [11:0] PH    = 12'(PAD_H);
  localparam logic signed [11:0] Q1    = 12'(PAD_H / 4);
  localparam logic signed [11:0] Q3    = 12'(PAD_H - PAD_H / 4);
  typedef enum logic [1:0] {SERVE = 2'b00, PLAY = 2'b01, OVER = 2'b10} state_t;
  logic [CNT_W-1:0] cnt;
  logic [SC_W-1:0] sc;
  logic [9:0] pl, pr, bx;
  logic [8:0] by;
  logic [3:0] sl, sr, sl_inc, sr_inc;
  logic signed [11:0] vx, vy, vy_w, bx_e, by_e, pl_e, pr_e, nx, ny, rel;
  logic last, hit_l, hit_r, score_l, score_r, wall;
  state_t st;
  function automatic logic [9:0] pad_mv(input logic [9:0] p, input logic [1:0] k);
    return k == 2'b10 ? (p < P_SPD ? 10'd0 : p - P_SPD) :
           k == 2'b01 ? (p > P_HI ? P_MAX : p + P_SPD) : p;
  endfunction
  assign last = cnt == T_LAST;
  assign bx_e = $signed({2'b00, bx});
  assign by_e = $signed({3'b000, by});
  assign pl_e = $signed({2'b00, pl});
  assign pr_e = $signed({2'b00, pr});
  assign sl_inc = sl + 4'd1;
  assign sr_inc = sr + 4'd1;
  // Hit tests use the paddle positions from before this tick's moves.
  always_comb begin
    nx = bx_e + vx;
    ny = by_e + vy;
    hit_l = vx < 12'sd0 && nx <= LF && bx_e >= LF && by_e + BS > pl_e && by_e < pl_e + PH;
    hit_r = vx > 12'sd0 && nx >= RF && bx_e <= RF && by_e + BS > pr_e && by_e < pr_e + PH;
    rel = by_e + HB - (hit_l ? pl_e : pr_e);
    wall = ny <= 12'sd0 || ny >= Y_MAX;
    vy_w = wall ? -vy : vy;
    score_l = !hit_r && nx >= X_MAX;
    score_r = !hit_l && nx <= 12'sd0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      sc <= '0;
      pl <= P_INIT;
      pr <= P_INIT;
      bx <= CX;
      by <= CY;
      vx <= V;
      vy <= V1;
      sl <= '0;
      sr <= '0;
      st <= SERVE;
    end else begin
      cnt <= last ? '0 : cnt + CNT_W'(1);
      if (last && !bus.pause) begin
        if (st != OVER) begin
          pl <= pad_mv(pl, bus.keys_left);
          pr <= pad_mv(pr, bus.keys_right);
        end
        case (st)
          SERVE: begin
            sc <= sc == SC_LAST ? '0 : sc + SC_W'(1);
            st <= sc == SC_LAST ? PLAY : SERVE;
          end
          PLAY: begin
            by <= (ny <= 12'sd0) ? 9'd0 : (ny >= Y_MAX) ? Y_MAX[8:0] : ny[8:0];
            vy <= (hit_l || hit_r) ? (rel < Q1 ? -V2 : rel >= Q3 ? V2 : vy_w < 12'sd0 ? -V1 : V1) : vy_w;
            if (hit_l || hit_r) begin
              bx <= hit_l ? LF[9:0] : RF[9:0];
              vx <= hit_l ? V : -V;
            end else if (score_l || score_r) begin
              sl <= score_l ? sl_inc : sl;
              sr <= score_r ? sr_inc : sr;
              st <= (score_l ? sl_inc : sr_inc) == MAX_S ? OVER : SERVE;
              bx <= CX;
              by <= CY;
              vx <= score_l ? V : -V;
              vy <= V1;
            end else begin
              bx <= nx[9:0];
            end
          end
          default: begin
            if (bus.keys_left == 2'b11 && bus.keys_right == 2'b11) begin
              sl <= '0;
              sr <= '0;
              st <= SERVE;
            end
          end
        endcase
      end
    end
  end
  assign bus.pad_left    = pl;
  assign bus.pad_right   = pr;
  assign bus.ball_x      = bx;
  assign bus.ball_y      = by;
  assign bus.score_left  = sl;
  assign bus.score_right = sr;
  assign bus.state       = st;
  assign bus.tick        = last;
endmodule

// File: tb/tb_pong_engine.sv
// tb_pong_engine: reference game model feeds a per-tick scoreboard; scenario tasks add fixed-value checks.
module tb_pong_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_assert = 0;
  int n_fail = 0;
  int m_pl, m_pr, m_bx, m_by, m_vx, m_vy, m_sl, m_sr, m_st, m_sc;
  typedef struct {int pl; int pr; int bx; int by; int sl; int sr; int st;} exp_t;
  exp_t q[$];
  exp_t e_in, e_out;
  integer got[7];
  integer want[7];
  string names[7] = '{"pad_left", "pad_right", "ball_x", "ball_y", "score_left", "score_right", "state"};
  always #5 clk = ~clk;
  pong_engine_if bus();
  pong_engine #(.TICK_DIV(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic m_reset();
    m_pl = 208; m_pr = 208; m_bx = 316; m_by = 236; m_vx = 2; m_vy = 1;
    m_sl = 0; m_sr = 0; m_st = 0; m_sc = 0;
  endtask
  function automatic int mv(input int p, input logic [1:0] k);
    if (k == 2'b10) return (p < 2) ? 0 : p - 2;
    if (k == 2'b01) return (p > 414) ? 416 : p + 2;
    return p;
  endfunction
  task automatic m_step(input logic [1:0] kl, input logic [1:0] kr);
    int pl0, pr0, nx, ny, rel;
    bit hl, hr;
    pl0 = m_pl;
    pr0 = m_pr;
    if (m_st != 2) begin
      m_pl = mv(m_pl, kl);
      m_pr = mv(m_pr, kr);
    end
    if (m_st == 0) begin
      if (m_sc == 59) begin m_st = 1; m_sc = 0; end
      else m_sc++;
    end else if (m_st == 1) begin
      nx = m_bx + m_vx;
      ny = m_by + m_vy;
      hl = m_vx < 0 && nx <= 24 && m_bx >= 24 && m_by + 8 > pl0 && m_by < pl0 + 64;
      hr = m_vx > 0 && nx >= 608 && m_bx <= 608 && m_by + 8 > pr0 && m_by < pr0 + 64;
      rel = m_by + 4 - (hl ? pl0 : pr0);
      if (ny <= 0) begin ny = 0; m_vy = -m_vy; end
      else if (ny >= 472) begin ny = 472; m_vy = -m_vy; end
      m_by = ny;
      if (hl || hr) begin
        m_bx = hl ? 24 : 608;
        m_vx = hl ? 2 : -2;
        if (rel < 16) m_vy = -2;
        else if (rel >= 48) m_vy = 2;
        else m_vy = (m_vy < 0) ? -1 : 1;
      end else if (nx <= 0 || nx >= 632) begin
        if (nx <= 0) begin m_sr++; m_vx = -2; end
        else begin m_sl++; m_vx = 2; end
        m_st = (m_sl == 9 || m_sr == 9) ? 2 : 0;
        m_bx = 316; m_by = 236; m_vy = 1;
      end else m_bx = nx;
    end else if (kl == 2'b11 && kr == 2'b11) begin
      m_sl = 0; m_sr = 0; m_st = 0;
    end
  endtask
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.tick === 1'b1) begin
      if (bus.pause === 1'b0) m_step(bus.keys_left, bus.keys_right);
      e_in = '{m_pl, m_pr, m_bx, m_by, m_sl, m_sr, m_st};
      q.push_back(e_in);
    end
  end
  always @(posedge clk) begin
    #1;
    if (rst === 1'b1 && q.size() > 0) begin
      e_out = q.pop_front();
      got = '{bus.pad_left, bus.pad_right, bus.ball_x, bus.ball_y, bus.score_left, bus.score_right, bus.state};
      want = '{e_out.pl, e_out.pr, e_out.bx, e_out.by, e_out.sl, e_out.sr, e_out.st};
      for (int i = 0; i < 7; i++) begin
        n_assert++;
        if (got[i] !== want[i]) begin
          n_fail++;
          $display("FAIL sb_%s got %0d want %0d at %0t", names[i], got[i], want[i], $time);
        end
      end
    end
  end
  task automatic ticks(input int n);
    int g;
    for (int k = 0; k < n; k++) begin
      g = 0;
      @(negedge clk);
      while (bus.tick !== 1'b1 && g < 16) begin
        @(negedge clk);
        g++;
      end
      if (g >= 16) begin
        n_assert++;
        n_fail++;
        $display("FAIL tick_timeout got no tick want one within 16 clk");
      end
      @(posedge clk);
      #2;
    end
  endtask
  function automatic logic [1:0] steer(input int pad, input int by);
    int t;
    t = by - 28;
    return (pad > t + 1) ? 2'b10 : (pad < t - 1) ? 2'b01 : 2'b00;
  endfunction
  task automatic test_reset();
    #2 rst = 1'b0;
    m_reset();
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    n_assert++; if (bus.pad_left !== 10'd208) begin n_fail++; $display("FAIL rst_pad_left got %0d want 208", bus.pad_left); end
    n_assert++; if (bus.pad_right !== 10'd208) begin n_fail++; $display("FAIL rst_pad_right got %0d want 208", bus.pad_right); end
    n_assert++; if (bus.ball_x !== 10'd316) begin n_fail++; $display("FAIL rst_ball_x got %0d want 316", bus.ball_x); end
    n_assert++; if (bus.ball_y !== 9'd236) begin n_fail++; $display("FAIL rst_ball_y got %0d want 236", bus.ball_y); end
    n_assert++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL rst_state got %0d want 0", bus.state); end
    n_assert++; if (bus.score_left !== 4'd0 || bus.score_right !== 4'd0) begin n_fail++; $display("FAIL rst_scores got %0d/%0d want 0/0", bus.score_left, bus.score_right); end
    n_assert++; if (bus.tick !== 1'b0) begin n_fail++; $display("FAIL rst_tick got %b want 0", bus.tick); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      n_assert++;
      if (bus.tick !== ((i % 4) == 3)) begin n_fail++; $display("FAIL tick_period cycle %0d got %b want %b", i, bus.tick, (i % 4) == 3); end
    end
    ticks(57);
    n_assert++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL serve_hold got %0d want 0", bus.state); end
    ticks(1);
    n_assert++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL serve_to_play got %0d want 1", bus.state); end
  endtask
  task automatic test_paddles();
    bus.keys_left = 2'b10;
    ticks(104);
    n_assert++; if (bus.pad_left !== 10'd0) begin n_fail++; $display("FAIL pad_up_sat got %0d want 0", bus.pad_left); end
    ticks(5);
    n_assert++; if (bus.pad_left !== 10'd0) begin n_fail++; $display("FAIL pad_up_hold got %0d want 0", bus.pad_left); end
    bus.keys_left = 2'b01;
    ticks(208);
    n_assert++; if (bus.pad_left !== 10'd416) begin n_fail++; $display("FAIL pad_down_sat got %0d want 416", bus.pad_left); end
    ticks(3);
    n_assert++; if (bus.pad_left !== 10'd416) begin n_fail++; $display("FAIL pad_down_hold got %0d want 416", bus.pad_left); end
    bus.keys_left = 2'b00;
  endtask
  task automatic test_right_scores();
    int b;
    b = 0;
    bus.keys_left = 2'b10;
    while (m_sr < 1 && b < 1500) begin
      bus.keys_right = steer(m_pr, m_by);
      ticks(1);
      b++;
    end
    n_assert++; if (bus.score_right !== 4'd1) begin n_fail++; $display("FAIL right_score got %0d want 1", bus.score_right); end
    n_assert++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL score_to_serve got %0d want 0", bus.state); end
    n_assert++; if (bus.ball_x !== 10'd316 || bus.ball_y !== 9'd236) begin n_fail++; $display("FAIL score_recentre got %0d,%0d want 316,236", bus.ball_x, bus.ball_y); end
    bus.keys_left = 2'b00;
    bus.keys_right = 2'b00;
    ticks(60);
    n_assert++; if (bus.state !== 2'd1 || bus.ball_x !== 10'd316) begin n_fail++; $display("FAIL reserve_play got %0d,%0d want 1,316", bus.state, bus.ball_x); end
    ticks(1);
    n_assert++; if (bus.ball_x !== 10'd314) begin n_fail++; $display("FAIL serve_toward_loser got %0d want 314", bus.ball_x); end
  endtask
  task automatic test_game_over();
    int b;
    b = 0;
    bus.keys_right = 2'b10;
    while (m_st != 2 && b < 8000) begin
      bus.keys_left = steer(m_pl, m_by);
      ticks(1);
      b++;
    end
    n_assert++; if (bus.state !== 2'd2) begin n_fail++; $display("FAIL over_state got %0d want 2", bus.state); end
    n_assert++; if (bus.score_left !== 4'd9) begin n_fail++; $display("FAIL over_score got %0d want 9", bus.score_left); end
    bus.keys_left = 2'b10;
    bus.keys_right = 2'b01;
    ticks(10);
    n_assert++; if (bus.state !== 2'd2) begin n_fail++; $display("FAIL over_frozen got %0d want 2", bus.state); end
    n_assert++; if (bus.ball_x !== 10'd316 || bus.ball_y !== 9'd236) begin n_fail++; $display("FAIL over_ball got %0d,%0d want 316,236", bus.ball_x, bus.ball_y); end
    bus.pause = 1'b1;
    bus.keys_left = 2'b11;
    bus.keys_right = 2'b11;
    ticks(5);
    n_assert++; if (bus.state !== 2'd2 || bus.score_left !== 4'd9) begin n_fail++; $display("FAIL pause_blocks_restart got %0d,%0d want 2,9", bus.state, bus.score_left); end
    bus.pause = 1'b0;
    ticks(1);
    n_assert++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL restart_state got %0d want 0", bus.state); end
    n_assert++; if (bus.score_left !== 4'd0 || bus.score_right !== 4'd0) begin n_fail++; $display("FAIL restart_scores got %0d/%0d want 0/0", bus.score_left, bus.score_right); end
    bus.keys_left = 2'b00;
    bus.keys_right = 2'b00;
  endtask
  task automatic test_pause_play();
    ticks(65);
    bus.pause = 1'b1;
    bus.keys_left = 2'b10;
    bus.keys_right = 2'b01;
    ticks(10);
    n_assert++; if (bus.state !== 2'd1 || bus.ball_x !== 10'd326) begin n_fail++; $display("FAIL pause_play got %0d,%0d want 1,326", bus.state, bus.ball_x); end
    bus.pause = 1'b0;
    ticks(10);
    bus.keys_left = 2'b00;
    bus.keys_right = 2'b00;
  endtask
  task automatic test_async_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    q.delete();
    m_reset();
    #1;
    n_assert++; if (bus.pad_left !== 10'd208 || bus.pad_right !== 10'd208) begin n_fail++; $display("FAIL async_pads got %0d,%0d want 208,208", bus.pad_left, bus.pad_right); end
    n_assert++; if (bus.ball_x !== 10'd316 || bus.ball_y !== 9'd236) begin n_fail++; $display("FAIL async_ball got %0d,%0d want 316,236", bus.ball_x, bus.ball_y); end
    n_assert++; if (bus.state !== 2'd0 || bus.tick !== 1'b0) begin n_fail++; $display("FAIL async_state got %0d,%b want 0,0", bus.state, bus.tick); end
    @(negedge clk);
    rst = 1'b1;
    ticks(3);
  endtask
  initial begin
    bus.pause = 1'b0;
    bus.keys_left = 2'b00;
    bus.keys_right = 2'b00;
    test_reset();
    test_paddles();
    test_right_scores();
    test_game_over();
    test_pause_play();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
